legv8_control_unit: RTL
=======================

Name: legv8_control_unit

Overview:
- Multi-cycle FSM that sequences the LEGv8 datapath.
- Drives the 34-bit datapath control word and the 64-bit constant bus.
- Reads the instruction register and the status register back from the datapath.
- Implements fetch/execute for a core LEGv8 subset and provides run/single-step debug control with a sticky halt on undefined opcodes.

Parameters:
- FS_ADD, 5'b01000, ALU function select for add (SUB = FS_ADD with C0=1 and inverted B).
- FS_SUB, 5'b01001, ALU function select for subtract.
- FS_AND, 5'b00000, ALU function select for AND.
- FS_ORR, 5'b00100, ALU function select for OR.
- SIZE_DW, 2'b11, memory size code for 64-bit doubleword.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- IR  in  32  instruction register contents.
- status_in  in  4  registered flags {V,C,N,Z}.
- run  in  1  level; 1 = free-running execution.
- step  in  1  one-cycle pulse; executes one instruction from IDLE.
- control_word  out  34  {AS[33], DS[32:31], PS[30:29], PCsel[28], Bsel[27], IL[26], SL[25], FS[24:20], C0[19], size[18:17], MW[16], RW[15], DA[14:10], SA[9:5], SB[4:0]}.
- constant  out  64  immediate/offset to datapath.
- state  out  3  current state (IDLE=0, FETCH=1, EXEC=2, BRANCH=3, HALT=4).
- halted  out  1  high in HALT.
- instr_count  out  32  retired-instruction counter.

Behaviour:
- Reset (async): state=IDLE, instr_count=0, halted=0. control_word=NOP=34'h2_0000_0000 (AS=1, all else 0). constant=0.
- control_word and constant are combinational from state and IR. No write enable (RW, MW, IL, SL) is ever high outside FETCH/EXEC.
- IDLE: NOP. If run=1 or step=1, go to FETCH. A step pulse latches a single-instruction flag.
- FETCH: AS=1, DS=11, IL=1, PS=01 (PC+4), size=SIZE_DW. Next state EXEC.
- EXEC (decode on IR):
  - ADD/SUB/AND/ORR (opcodes 10001011000/11001011000/10001010000/10101010000): SA=Rn, SB=Rm, DA=Rd, Bsel=0, DS=00, RW=1.
  - ADDI/SUBI (1001000100/1101000100): Bsel=1, constant = zero-extended imm12, RW=1.
  - LDUR (11111000010): SA=Rn, Bsel=1, constant = sign-extended imm9, FS_ADD, AS=0, DS=11, DA=Rt, RW=1, size=SIZE_DW.
  - STUR (11111000000): same address path; SB=Rt, DS=01, MW=1, RW=0.
  - B (000101): PS=10, constant = sext(imm26<<2) - 4.
  - CBZ/CBNZ (10110100/10110101): SA=Rt, Bsel=1, constant=0, FS_ADD, SL=1, RW=0. Next state BRANCH.
  - Any other opcode: go to HALT with NOP word; instr_count does not increment.
- BRANCH: if (CBZ and Z=1) or (CBNZ and Z=0), PS=10 with constant = sext(imm19<<2) - 4; otherwise PS=00.
- The -4 correction compensates for PC already advanced in FETCH.
- Retire: on leaving EXEC (non-CB) or BRANCH, instr_count += 1, wrapping at 2^32. Next state is FETCH if run=1 and no step flag, else IDLE; step flag cleared.
- HALT: sticky until reset. run and step are ignored.
- SUB/SUBI: FS_SUB with C0=1. SA/SB/DA fields are 0 whenever unused.
- Register 31 as DA is written as decoded; the datapath handles XZR.
- run deasserting mid-instruction completes the current instruction, then enters IDLE.
- step while run=1 has no extra effect.
- Reset mid-FETCH/EXEC: immediately return to IDLE with NOP. No write strobe glitches after reset assertion.

Test Plan:
- Reset, run=1, IR=ADD X3,X1,X2 (0x8B020023) -> FETCH word has IL=1,PS=01,AS=1,DS=11; EXEC word has DA=3,SA=1,SB=2,RW=1,FS=01000; instr_count=1.
- IR=ADDI X5,X5,#0xFFF -> constant=64'h0FFF, Bsel=1, DA=5; IR=LDUR X2,[X4,#-8] -> constant=64'hFFFF_FFFF_FFFF_FFF8, AS=0, DS=11, RW=1, DA=2.
- STUR X7,[X0,#16] -> MW=1, DS=01, SB=7, RW=0, constant=16.
- CBZ X9,#+3 instr: status_in Z=1 in BRANCH -> PS=10, constant=8; with Z=0 -> PS=00; instr_count +1 either way, 3 cycles total.
- B #-1 -> PS=10, constant=64'hFFFF_FFFF_FFFF_FFF8.
- run=0, one step pulse in IDLE -> exactly one FETCH/EXEC then IDLE. Undefined IR 0x00000000 -> HALT, halted=1, run ignored until reset.

Source files
------------

// File: rtl/legv8_control_unit.sv
// -----------------------------------------------------------------------------
// legv8_control_unit
// Multi-cycle sequencer for the LEGv8 datapath. It steps through FETCH and
// EXEC, plus BRANCH for CBZ/CBNZ, and drives the datapath control word and the
// constant bus. It also provides run/single-step debug control. An undefined
// opcode parks the unit in HALT until reset.
//
// Ports:
//   clock        in   1   system clock, rising edge
//   reset        in   1   asynchronous, active-high
//   IR           in  32   instruction register contents
//   status_in    in   4   registered flags {V,C,N,Z}
//   run          in   1   level, free-running execution
//   step         in   1   one-cycle pulse, executes one instruction from IDLE
//   control_word out 34   {AS,DS,PS,PCsel,Bsel,IL,SL,FS,C0,size,MW,RW,DA,SA,SB}
//   constant     out 64   immediate/offset to the datapath
//   state        out  3   IDLE=0 FETCH=1 EXEC=2 BRANCH=3 HALT=4
//   halted       out  1   high while in HALT
//   instr_count  out 32   retired-instruction counter
// -----------------------------------------------------------------------------
module legv8_control_unit #(
  parameter logic [4:0] FS_ADD  = 5'b01000,
  parameter logic [4:0] FS_SUB  = 5'b01001,
  parameter logic [4:0] FS_AND  = 5'b00000,
  parameter logic [4:0] FS_ORR  = 5'b00100,
  parameter logic [1:0] SIZE_DW = 2'b11
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic [3:0]  status_in,
  input  logic        run,
  input  logic        step,
  output logic [33:0] control_word,
  output logic [63:0] constant,
  output logic [2:0]  state,
  output logic        halted,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_BRANCH = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        step_q, step_d;
  logic [31:0] count_q, count_d;

  logic is_r_s, is_addi_s, is_subi_s, is_ldur_s, is_stur_s, is_b_s, is_cb_s;
  logic is_valid_s, br_taken_s;

  logic       as_s, pcsel_s, bsel_s, il_s, sl_s, c0_s, mw_s, rw_s;
  logic [1:0] ds_s, ps_s, size_s;
  logic [4:0] fs_s, da_s, sa_s, sb_s;
  logic [63:0] const_s;

  // Only Z steers the sequencer; V, C and N are carried for the datapath.
  logic unused_flags;
  assign unused_flags = ^status_in[3:1];

  // Opcode decode of the instruction register.
  always_comb begin
    is_r_s    = (IR[31:21] == 11'b10001011000) || (IR[31:21] == 11'b11001011000) ||
                (IR[31:21] == 11'b10001010000) || (IR[31:21] == 11'b10101010000);
    is_addi_s = (IR[31:22] == 10'b1001000100);
    is_subi_s = (IR[31:22] == 10'b1101000100);
    is_ldur_s = (IR[31:21] == 11'b11111000010);
    is_stur_s = (IR[31:21] == 11'b11111000000);
    is_b_s    = (IR[31:26] == 6'b000101);
    is_cb_s   = (IR[31:25] == 7'b1011010);   // CBZ/CBNZ differ only in bit 24
    is_valid_s = is_r_s | is_addi_s | is_subi_s | is_ldur_s | is_stur_s | is_b_s | is_cb_s;
    // IR[24]=1 is CBNZ (branch on Z=0), otherwise CBZ (branch on Z=1).
    br_taken_s = IR[24] ? ~status_in[0] : status_in[0];
  end

  // State, single-step flag and retire counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      count_q <= count_d;
    end
  end

  // Next-state logic: sequencing, step flag and instruction retirement.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (run || step) begin
          state_d = S_FETCH;
          // A step while running changes nothing, so the flag only arms with run low.
          step_d  = step & ~run;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        if (!is_valid_s) begin
          state_d = S_HALT;
        end else if (is_cb_s) begin
          state_d = S_BRANCH;
        end else begin
          count_d = count_q + 32'd1;
          state_d = (run && !step_q) ? S_FETCH : S_IDLE;
          step_d  = 1'b0;
        end
      end
      S_BRANCH: begin
        count_d = count_q + 32'd1;
        state_d = (run && !step_q) ? S_FETCH : S_IDLE;
        step_d  = 1'b0;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: the control word and constant for the current state and IR.
  // Every field defaults to the NOP value (AS=1, everything else 0).
  always_comb begin
    as_s = 1'b1; ds_s = 2'b00; ps_s = 2'b00; pcsel_s = 1'b0;
    bsel_s = 1'b0; il_s = 1'b0; sl_s = 1'b0; fs_s = 5'b00000; c0_s = 1'b0;
    size_s = 2'b00; mw_s = 1'b0; rw_s = 1'b0;
    da_s = 5'd0; sa_s = 5'd0; sb_s = 5'd0;
    const_s = 64'd0;
    case (state_q)
      S_FETCH: begin
        ds_s = 2'b11; il_s = 1'b1; ps_s = 2'b01; size_s = SIZE_DW;
      end
      S_EXEC: begin
        if (is_r_s) begin
          sa_s = IR[9:5]; sb_s = IR[20:16]; da_s = IR[4:0]; rw_s = 1'b1;
          case (IR[31:21])
            11'b11001011000: begin fs_s = FS_SUB; c0_s = 1'b1; end
            11'b10001010000: fs_s = FS_AND;
            11'b10101010000: fs_s = FS_ORR;
            default:         fs_s = FS_ADD;
          endcase
        end else if (is_addi_s || is_subi_s) begin
          sa_s = IR[9:5]; da_s = IR[4:0]; bsel_s = 1'b1; rw_s = 1'b1;
          const_s = {52'd0, IR[21:10]};
          fs_s = is_subi_s ? FS_SUB : FS_ADD;
          c0_s = is_subi_s;
        end else if (is_ldur_s || is_stur_s) begin
          // Both take their address as Rn + sext(imm9) from the ALU.
          as_s = 1'b0; sa_s = IR[9:5]; bsel_s = 1'b1; fs_s = FS_ADD; size_s = SIZE_DW;
          const_s = {{55{IR[20]}}, IR[20:12]};
          if (is_ldur_s) begin
            ds_s = 2'b11; da_s = IR[4:0]; rw_s = 1'b1;
          end else begin
            ds_s = 2'b01; sb_s = IR[4:0]; mw_s = 1'b1;
          end
        end else if (is_b_s) begin
          // PC was already advanced by 4 during FETCH.
          ps_s = 2'b10;
          const_s = {{36{IR[25]}}, IR[25:0], 2'b00} - 64'd4;
        end else if (is_cb_s) begin
          // Pass Rt through the ALU so Z reflects Rt==0 in BRANCH.
          sa_s = IR[4:0]; bsel_s = 1'b1; fs_s = FS_ADD; sl_s = 1'b1;
        end else begin
          as_s = 1'b1;   // undefined opcode: NOP on the way to HALT
        end
      end
      S_BRANCH: begin
        if (br_taken_s) begin
          ps_s = 2'b10;
          const_s = {{43{IR[23]}}, IR[23:5], 2'b00} - 64'd4;
        end else begin
          ps_s = 2'b00;
        end
      end
      default: as_s = 1'b1;
    endcase
  end

  assign control_word = {as_s, ds_s, ps_s, pcsel_s, bsel_s, il_s, sl_s, fs_s, c0_s,
                         size_s, mw_s, rw_s, da_s, sa_s, sb_s};
  assign constant     = const_s;
  assign state        = state_q;
  assign halted       = (state_q == S_HALT);
  assign instr_count  = count_q;

endmodule
